// File: rtl/servo_pkg.sv
`default_nettype none
// ============================================================================
// servo_pkg
// Shared defaults and width helpers for the multi-channel servo PWM block.
// Revision: 1.0
// ============================================================================
package servo_pkg;

   localparam int NUM_CANAIS_PADRAO      = 4;
   localparam int CONF_PERIODO_PADRAO    = 1000000;
   localparam int LARGURA_MIN_PADRAO     = 50000;
   localparam int LARGURA_MAX_PADRAO     = 100000;
   localparam int LARGURA_INICIAL_PADRAO = 75000;
   localparam int PASSO_PADRAO           = 1000;

   // Width able to hold any value 0..periodo inclusive.
   function automatic int lw_f(input int periodo);
      return $clog2(periodo + 1);
   endfunction

   function automatic int cw_f(input int canais);
      return (canais > 1) ? $clog2(canais) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/canal_pwm_rampa.sv
`default_nettype none
// ============================================================================
// canal_pwm_rampa
// One servo channel: target/applied width, slew-limited ramp, PWM compare.
// Revision: 1.0
// ============================================================================
module canal_pwm_rampa
   import servo_pkg::*;
#(
   parameter int LW              = lw_f(CONF_PERIODO_PADRAO),
   parameter int PASSO           = PASSO_PADRAO,
   parameter int LARGURA_INICIAL = LARGURA_INICIAL_PADRAO
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          fim_periodo,
   input  logic          habilita,
   input  logic          escreve,
   input  logic [LW-1:0] largura,
   input  logic [LW-1:0] contagem,
   output logic          pwm,
   output logic          ocupado
);

   localparam logic [LW:0]   PASSO_X   = (LW + 1)'(PASSO);
   localparam logic [LW-1:0] INICIAL_W = LW'(LARGURA_INICIAL);

   logic [LW-1:0] alvo_q, alvo_d;
   logic [LW-1:0] atual_q, atual_d;
   logic          pwm_q, pwm_d;
   logic [LW:0]   atual_x, alvo_x;

   always_comb begin
      atual_x = {1'b0, atual_q};
      alvo_x  = {1'b0, alvo_q};
      alvo_d  = escreve ? largura : alvo_q;
      atual_d = atual_q;
      // The step uses the pre-edge target, so a write landing on the boundary
      // clock only influences the following boundary.
      if (fim_periodo && habilita) begin
         if ((alvo_x > atual_x) && ((alvo_x - atual_x) > PASSO_X)) begin
            atual_d = LW'(atual_x + PASSO_X);
         end else if ((atual_x > alvo_x) && ((atual_x - alvo_x) > PASSO_X)) begin
            atual_d = LW'(atual_x - PASSO_X);
         end else begin
            atual_d = alvo_q;
         end
      end
      pwm_d = habilita && (contagem < atual_q);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         alvo_q  <= INICIAL_W;
         atual_q <= INICIAL_W;
         pwm_q   <= 1'b0;
      end else begin
         alvo_q  <= alvo_d;
         atual_q <= atual_d;
         pwm_q   <= pwm_d;
      end
   end

   assign pwm     = pwm_q;
   assign ocupado = (atual_q != alvo_q);

endmodule
`default_nettype wire

// File: rtl/circuito_pwm_multi.sv
`default_nettype none
// ============================================================================
// circuito_pwm_multi
// Multi-channel servo PWM: shared period counter, command decode, N channels.
// Revision: 1.0
// ============================================================================
module circuito_pwm_multi
   import servo_pkg::*;
#(
   parameter int NUM_CANAIS      = NUM_CANAIS_PADRAO,
   parameter int CONF_PERIODO    = CONF_PERIODO_PADRAO,
   parameter int LARGURA_MIN     = LARGURA_MIN_PADRAO,
   parameter int LARGURA_MAX     = LARGURA_MAX_PADRAO,
   parameter int LARGURA_INICIAL = LARGURA_INICIAL_PADRAO,
   parameter int PASSO           = PASSO_PADRAO
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            cmd_valid,
   output logic                            cmd_ready,
   input  logic [cw_f(NUM_CANAIS)-1:0]     cmd_canal,
   input  logic [lw_f(CONF_PERIODO)-1:0]   cmd_largura,
   input  logic [NUM_CANAIS-1:0]           habilita,
   output logic [NUM_CANAIS-1:0]           pwm,
   output logic [NUM_CANAIS-1:0]           ocupado,
   output logic                            fim_periodo
);

   localparam int            LW      = lw_f(CONF_PERIODO);
   localparam int            CW      = cw_f(NUM_CANAIS);
   localparam logic [LW-1:0] ULTIMA  = LW'(CONF_PERIODO - 1);
   localparam logic [LW-1:0] MIN_W   = LW'(LARGURA_MIN);
   localparam logic [LW-1:0] MAX_W   = LW'(LARGURA_MAX);

   logic [LW-1:0] contagem_q, contagem_d;
   logic          cmd_ready_q, cmd_ready_d;
   logic [LW-1:0] largura_sat;
   logic          aceita;

   always_comb begin
      contagem_d  = (contagem_q == ULTIMA) ? '0 : contagem_q + LW'(1);
      cmd_ready_d = 1'b1;
      aceita      = cmd_valid && cmd_ready_q;
      if (cmd_largura < MIN_W) begin
         largura_sat = MIN_W;
      end else if (cmd_largura > MAX_W) begin
         largura_sat = MAX_W;
      end else begin
         largura_sat = cmd_largura;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         contagem_q  <= '0;
         cmd_ready_q <= 1'b0;
      end else begin
         contagem_q  <= contagem_d;
         cmd_ready_q <= cmd_ready_d;
      end
   end

   assign cmd_ready   = cmd_ready_q;
   assign fim_periodo = (contagem_q == ULTIMA);

   // An index beyond the last channel matches no instance and is dropped.
   generate
      for (genvar i = 0; i < NUM_CANAIS; i++) begin : g_canal
         logic escreve;
         assign escreve = aceita && (cmd_canal == CW'(i));

         canal_pwm_rampa #(
            .LW              (LW),
            .PASSO           (PASSO),
            .LARGURA_INICIAL (LARGURA_INICIAL)
         ) u_canal (
            .clock       (clock),
            .reset       (reset),
            .fim_periodo (fim_periodo),
            .habilita    (habilita[i]),
            .escreve     (escreve),
            .largura     (largura_sat),
            .contagem    (contagem_q),
            .pwm         (pwm[i]),
            .ocupado     (ocupado[i])
         );
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_circuito_pwm_multi.sv
`default_nettype none
// ============================================================================
// tb_circuito_pwm_multi
// Directed bench: 2-channel instance, period 100, widths 10..30, step 4.
// Revision: 1.0
// ============================================================================
module tb_circuito_pwm_multi;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic       cmd_canal = 1'b0;
   logic [6:0] cmd_largura = '0;
   logic [1:0] habilita = 2'b11;
   logic [1:0] pwm, ocupado;
   logic       fim_periodo;

   logic       cmd_valid3 = 1'b0;
   logic       cmd_ready3;
   logic [1:0] cmd_canal3 = '0;
   logic [6:0] cmd_largura3 = '0;
   logic [2:0] habilita3 = 3'b111;
   logic [2:0] pwm3, ocupado3;
   logic       fim_periodo3;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   circuito_pwm_multi #(
      .NUM_CANAIS(2), .CONF_PERIODO(100), .LARGURA_MIN(10),
      .LARGURA_MAX(30), .LARGURA_INICIAL(20), .PASSO(4)
   ) dut (
      .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_canal(cmd_canal), .cmd_largura(cmd_largura), .habilita(habilita),
      .pwm(pwm), .ocupado(ocupado), .fim_periodo(fim_periodo)
   );

   circuito_pwm_multi #(
      .NUM_CANAIS(3), .CONF_PERIODO(100), .LARGURA_MIN(10),
      .LARGURA_MAX(30), .LARGURA_INICIAL(20), .PASSO(4)
   ) dut3 (
      .clock(clock), .reset(reset), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
      .cmd_canal(cmd_canal3), .cmd_largura(cmd_largura3), .habilita(habilita3),
      .pwm(pwm3), .ocupado(ocupado3), .fim_periodo(fim_periodo3)
   );

   task automatic wait_fim(input int budget);
      int n;
      n = 0;
      @(negedge clock);
      while (!fim_periodo && n < budget) begin
         @(negedge clock);
         n++;
      end
      checks++;
      if (fim_periodo !== 1'b1) begin
         failures++;
         $display("FAIL wait_fim: fim_periodo=%b required 1 within %0d clocks", fim_periodo, budget);
      end
   endtask

   // Called at the negedge showing contagem=99; samples contagem 0..99.
   task automatic measure_period(input int cmd_at, input logic canal, input logic [6:0] larg,
                                 output int w0, output int w1, output int nfim);
      w0 = 0; w1 = 0; nfim = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clock);
         cmd_valid = 1'b0;
         if (pwm[0]) w0++;
         if (pwm[1]) w1++;
         if (fim_periodo) nfim++;
         if (k == cmd_at) begin
            cmd_valid   = 1'b1;
            cmd_canal   = canal;
            cmd_largura = larg;
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clock);
      checks++;
      if (pwm !== 2'b00 || fim_periodo !== 1'b0 || cmd_ready !== 1'b0 || ocupado !== 2'b00) begin
         failures++;
         $display("FAIL reset_state: pwm=%b fim=%b ready=%b ocupado=%b required 00 0 0 00",
                  pwm, fim_periodo, cmd_ready, ocupado);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (cmd_ready !== 1'b0) begin
         failures++;
         $display("FAIL ready_before_edge: cmd_ready=%b required 0", cmd_ready);
      end
      @(posedge clock); #1;
      checks++;
      if (cmd_ready !== 1'b1 || cmd_ready3 !== 1'b1) begin
         failures++;
         $display("FAIL ready_after_edge: cmd_ready=%b cmd_ready3=%b required 1 1", cmd_ready, cmd_ready3);
      end
   endtask

   task automatic test_basic();
      int w0, w1, nf;
      wait_fim(150);
      for (int p = 0; p < 2; p++) begin
         measure_period(-1, 1'b0, 7'd0, w0, w1, nf);
         checks++;
         if (w0 != 20 || w1 != 20 || nf != 1 || fim_periodo !== 1'b1 || ocupado !== 2'b00) begin
            failures++;
            $display("FAIL basic_period%0d: w0=%0d w1=%0d nfim=%0d fim=%b ocupado=%b required 20 20 1 1 00",
                     p, w0, w1, nf, fim_periodo, ocupado);
         end
      end
   endtask

   task automatic test_ramp();
      int w0, w1, nf;
      int exp0[5]     = '{20, 24, 28, 30, 30};
      logic exp_oc[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      for (int p = 0; p < 5; p++) begin
         measure_period((p == 0) ? 10 : -1, 1'b0, 7'd30, w0, w1, nf);
         checks++;
         if (w0 != exp0[p] || w1 != 20 || ocupado[0] !== exp_oc[p]) begin
            failures++;
            $display("FAIL ramp_period%0d: w0=%0d w1=%0d ocupado0=%b required %0d 20 %b",
                     p, w0, w1, ocupado[0], exp0[p], exp_oc[p]);
         end
      end
   endtask

   task automatic test_clamp();
      int w0, w1, nf, at;
      logic [6:0] lg;
      int exp1[10]     = '{20, 16, 12, 10, 10, 14, 18, 22, 26, 30};
      logic exp_oc[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      for (int p = 0; p < 10; p++) begin
         at = (p == 0) ? 10 : ((p == 4) ? 20 : -1);
         lg = (p == 0) ? 7'd5 : 7'd99;
         measure_period(at, 1'b1, lg, w0, w1, nf);
         checks++;
         if (w1 != exp1[p] || w0 != 30 || ocupado[1] !== exp_oc[p]) begin
            failures++;
            $display("FAIL clamp_period%0d: w1=%0d w0=%0d ocupado1=%b required %0d 30 %b",
                     p, w1, w0, ocupado[1], exp1[p], exp_oc[p]);
         end
      end
   endtask

   task automatic test_cmd_on_fim();
      int w0, w1, nf;
      int exp0[3]     = '{30, 30, 26};
      logic exp_oc[3] = '{1'b0, 1'b1, 1'b1};
      for (int p = 0; p < 3; p++) begin
         measure_period((p == 0) ? 99 : -1, 1'b0, 7'd10, w0, w1, nf);
         checks++;
         if (w0 != exp0[p] || w1 != 30 || ocupado[0] !== exp_oc[p]) begin
            failures++;
            $display("FAIL cmd_on_fim_period%0d: w0=%0d w1=%0d ocupado0=%b required %0d 30 %b",
                     p, w0, w1, ocupado[0], exp0[p], exp_oc[p]);
         end
      end
   endtask

   task automatic test_enable();
      int w0, w1, nf;
      int exp0[4] = '{0, 0, 22, 18};
      for (int p = 0; p < 4; p++) begin
         habilita = (p < 2) ? 2'b10 : 2'b11;
         measure_period(-1, 1'b0, 7'd0, w0, w1, nf);
         checks++;
         if (w0 != exp0[p] || w1 != 30 || ocupado[0] !== 1'b1) begin
            failures++;
            $display("FAIL enable_period%0d: w0=%0d w1=%0d ocupado0=%b required %0d 30 1",
                     p, w0, w1, ocupado[0], exp0[p]);
         end
      end
   endtask

   task automatic test_discard();
      @(negedge clock);
      cmd_valid3 = 1'b1; cmd_canal3 = 2'd3; cmd_largura3 = 7'd30;
      @(negedge clock);
      cmd_valid3 = 1'b0;
      repeat (2) @(negedge clock);
      checks++;
      if (ocupado3 !== 3'b000) begin
         failures++;
         $display("FAIL discard_canal3: ocupado3=%b required 000", ocupado3);
      end
      cmd_valid3 = 1'b1; cmd_canal3 = 2'd2; cmd_largura3 = 7'd30;
      @(negedge clock);
      cmd_valid3 = 1'b0;
      checks++;
      if (ocupado3 !== 3'b100) begin
         failures++;
         $display("FAIL write_canal2: ocupado3=%b required 100", ocupado3);
      end
   endtask

   task automatic test_reset_mid();
      int w0, w1, nf;
      wait_fim(150);
      repeat (6) @(negedge clock);
      checks++;
      if (pwm !== 2'b11) begin
         failures++;
         $display("FAIL pre_reset_pwm: pwm=%b required 11", pwm);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (pwm !== 2'b00 || fim_periodo !== 1'b0 || cmd_ready !== 1'b0 || ocupado !== 2'b00) begin
         failures++;
         $display("FAIL mid_reset: pwm=%b fim=%b ready=%b ocupado=%b required 00 0 0 00",
                  pwm, fim_periodo, cmd_ready, ocupado);
      end
      repeat (2) @(negedge clock);
      reset = 1'b1;
      #1;
      checks++;
      if (cmd_ready !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset_release: cmd_ready=%b required 0", cmd_ready);
      end
      @(posedge clock); #1;
      checks++;
      if (cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL mid_reset_ready: cmd_ready=%b required 1", cmd_ready);
      end
      wait_fim(150);
      measure_period(-1, 1'b0, 7'd0, w0, w1, nf);
      checks++;
      if (w0 != 20 || w1 != 20 || ocupado !== 2'b00) begin
         failures++;
         $display("FAIL after_reset_period: w0=%0d w1=%0d ocupado=%b required 20 20 00", w0, w1, ocupado);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ramp();
      test_clamp();
      test_cmd_on_fim();
      test_enable();
      test_discard();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/circuito_pwm_multi.md
CIRCUITO_PWM_MULTI -- requirements
Module: circuito_pwm_multi

Interface
REQ-001 The block SHALL have parameter NUM_CANAIS, default 4, meaning the number of independent servo PWM channels (1..16).
REQ-002 The block SHALL have parameter CONF_PERIODO, default 1000000, meaning the PWM period in clocks (20 ms at 50 MHz).
REQ-003 The block SHALL have parameter LARGURA_MIN, default 50000, meaning the minimum high time in clocks (1 ms).
REQ-004 The block SHALL have parameter LARGURA_MAX, default 100000, meaning the maximum high time in clocks (2 ms).
REQ-005 The block SHALL have parameter LARGURA_INICIAL, default 75000, meaning the high time of every channel after reset.
REQ-006 The block SHALL have parameter PASSO, default 1000, meaning the maximum high-time change per channel per period (slew limit).
REQ-007 The block SHALL have port clock, input, 1 bit, meaning the single system clock (all logic on its rising edge).
REQ-008 The block SHALL have port reset, input, 1 bit, meaning asynchronous active-low reset (logic reset while reset=0).
REQ-009 The block SHALL have port cmd_valid, input, 1 bit, meaning a new target width is offered.
REQ-010 The block SHALL have port cmd_ready, output, 1 bit, meaning the block accepts a command this cycle.
REQ-011 The block SHALL have port cmd_canal, input, CW=max(1,$clog2(NUM_CANAIS)) bits, meaning the channel index addressed.
REQ-012 The block SHALL have port cmd_largura, input, LW=$clog2(CONF_PERIODO+1) bits, meaning the requested high time in clocks.
REQ-013 The block SHALL have port habilita, input, NUM_CANAIS bits, meaning a per-channel output enable.
REQ-014 The block SHALL have port pwm, output, NUM_CANAIS bits, meaning the registered per-channel PWM outputs.
REQ-015 The block SHALL have port ocupado, output, NUM_CANAIS bits, meaning the channel's current width differs from its target (ramp in progress).
REQ-016 The block SHALL have port fim_periodo, output, 1 bit, meaning a one-clock pulse on the last clock of each period.

Function
REQ-017 A single shared counter contagem SHALL count 0..CONF_PERIODO-1 and wrap to 0; fim_periodo=1 exactly when contagem==CONF_PERIODO-1.
REQ-018 Each channel SHALL hold registers atual (applied width) and alvo (target width), both LW bits.
REQ-019 A command SHALL be accepted on a clock where cmd_valid=1 and cmd_ready=1; cmd_ready SHALL be 1 in every cycle after reset release.
REQ-020 On acceptance, alvo[cmd_canal] SHALL load cmd_largura clamped to [LARGURA_MIN, LARGURA_MAX] on the next edge.
REQ-021 A command with cmd_canal>=NUM_CANAIS SHALL be accepted and discarded with no state change.
REQ-022 On the fim_periodo clock, each enabled channel SHALL update atual by at most PASSO toward alvo: atual+PASSO if alvo-atual>PASSO; atual-PASSO if atual-alvo>PASSO; else alvo.
REQ-023 Ramp arithmetic SHALL be carried out at LW+1 bits so no intermediate overflows or underflows.
REQ-024 atual SHALL change only on the fim_periodo clock, so every period is emitted with one constant width (glitch-free).
REQ-025 A command accepted on the fim_periodo clock SHALL NOT affect that boundary's ramp step; it takes effect from the next boundary.
REQ-026 pwm[i] SHALL be registered as habilita[i] && (contagem < atual[i]), one-clock latency from contagem.
REQ-027 With habilita[i]=0, pwm[i] SHALL be 0 and atual[i] SHALL be frozen; alvo[i] SHALL still accept commands, and the ramp resumes at the first boundary with habilita[i]=1.
REQ-028 ocupado[i] SHALL be combinational (atual[i]!=alvo[i]).

Reset
REQ-029 While reset=0: contagem=0, pwm=0, fim_periodo=0, cmd_ready=0, every atual and alvo=LARGURA_INICIAL, ocupado=0.
REQ-030 Reset asserted mid-period or mid-ramp SHALL abort immediately with no partial pulse; after release, the first period starts at contagem=0.
REQ-031 cmd_ready SHALL rise on the first clock edge after reset release.

Structure
REQ-032 Default parameter values and the LW/CW width functions SHALL reside in shared package servo_pkg.
REQ-033 Per-channel alvo/atual/ramp/compare logic SHALL be a sub-module canal_pwm_rampa, instantiated NUM_CANAIS times by a generate loop; the counter and command decode SHALL live in the top module.

Verification (NUM_CANAIS=2, CONF_PERIODO=100, MIN=10, MAX=30, INICIAL=20, PASSO=4)
REQ-034 Release reset, habilita=11 -> both pwm high for 20 clocks per 100-clock period; ocupado=00; fim_periodo every 100 clocks.
REQ-035 Command canal 0, largura 30 -> ocupado[0]=1; successive periods show widths 20,24,28,30,30; ocupado[0] falls when atual=30.
REQ-036 Command canal 1, largura 5, then canal 1, largura 99 -> targets clamped to 10 and 30; no period width outside [10,30].
REQ-037 Command issued on the fim_periodo clock -> the width for the following period is unchanged; the ramp starts one period later.
REQ-038 habilita[0]=0 during a ramp -> pwm[0]=0 and the width is frozen; re-enable -> the ramp continues from the frozen value. Command canal 3 -> no change on either channel.
REQ-039 Assert reset at contagem=5 mid-ramp -> pwm=00 immediately; after release, widths return to 20 and cmd_ready=1 one clock later.
